// File: rtl/zir_pkg.sv
// zir_pkg: constants and state encoding shared by the ZIR command ROM and
// the response parser.
//   ZIR_HDR / ZIR_TAIL0 / ZIR_TAIL1 : frame delimiters
//   ZIR_ERR_*                       : error codes reported on oErrCode
//   zir_state_e                     : response parser FSM states
package zir_pkg;

  localparam logic [7:0] ZIR_HDR   = 8'hAA;
  localparam logic [7:0] ZIR_TAIL0 = 8'hEB;
  localparam logic [7:0] ZIR_TAIL1 = 8'hAA;

  localparam logic [1:0] ZIR_ERR_LEN  = 2'd0;
  localparam logic [1:0] ZIR_ERR_CHK  = 2'd1;
  localparam logic [1:0] ZIR_ERR_TAIL = 2'd2;
  localparam logic [1:0] ZIR_ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StBody,
    StChk,
    StTail0,
    StTail1
  } zir_state_e;

endpackage

// File: rtl/zir_body_buf.sv
// zir_body_buf: double-buffered MAX_BODY x 8 body storage.
// Writes always land in the shadow bank; swap_i flips which bank is visible
// on the read port, so a committed body stays readable while the next frame
// is being received.
//   clk_i, rst_i : clock, synchronous active-high reset (resets bank select)
//   wr_en_i      : write wr_data_i into shadow[wr_idx_i]
//   swap_i       : make the shadow bank the read bank
//   rd_idx_i     : read address
//   rd_len_i     : number of valid bytes in the read bank
//   rd_data_o    : read bank byte, 0 when rd_idx_i >= rd_len_i
module zir_body_buf #(
  parameter int unsigned MAX_BODY = 16,
  parameter int unsigned IdxW     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [7:0]      wr_data_i,
  input  logic            swap_i,
  input  logic [3:0]      rd_idx_i,
  input  logic [4:0]      rd_len_i,
  output logic [7:0]      rd_data_o
);

  logic [7:0] mem_q [2][MAX_BODY];
  logic       bank_q;  // bank currently visible on the read port

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q <= 1'b0;
    end else if (swap_i) begin
      bank_q <= ~bank_q;
    end
  end

  // Storage needs no reset: rd_len_i = 0 after reset masks stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[~bank_q][wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = 8'h00;
    if ({1'b0, rd_idx_i} < rd_len_i) begin
      rd_data_o = mem_q[bank_q][rd_idx_i[IdxW-1:0]];
    end
  end

endmodule

// File: rtl/zir_resp_parser.sv
// zir_resp_parser: parses IR module response frames from the UART byte
// stream.  Frame: AA, LEN, BODY[LEN-1], CHK, EB, AA where CHK is the mod-256
// sum of AA, LEN and the body bytes.
//   iClk, iRst   : clock, synchronous active-high reset
//   iRxValid     : iRxData holds a received byte this cycle
//   iRxData      : received byte
//   iRdIndex     : body read address
//   oRdData      : body byte of the last good frame (0 past oBodyLen)
//   oBodyLen     : body length of the last good frame
//   oFrameOk     : one-cycle pulse, good frame committed
//   oFrameErr    : one-cycle pulse, frame rejected
//   oErrCode     : reason of the most recent rejection
//   oBusy        : a frame is in progress
// MAX_BODY must be in 1..16 (4-bit read address); TIMEOUT_CYC >= 2.
module zir_resp_parser
  import zir_pkg::*;
#(
  parameter int unsigned MAX_BODY    = 16,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRxValid,
  input  logic [7:0] iRxData,
  input  logic [3:0] iRdIndex,
  output logic [7:0] oRdData,
  output logic [4:0] oBodyLen,
  output logic       oFrameOk,
  output logic       oFrameErr,
  output logic [1:0] oErrCode,
  output logic       oBusy
);

  localparam int unsigned   IdxW     = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;
  localparam int unsigned   TmoW     = $clog2(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    LenMax   = 8'(MAX_BODY + 1);

  zir_state_e      state_q;
  logic [7:0]      sum_q;
  logic [4:0]      cnt_q;
  logic [4:0]      idx_q;
  logic [TmoW-1:0] tmo_q;
  logic            chk_err_q;  // checksum failed, reported once trailer is consumed
  logic            frame_ok_q;
  logic            frame_err_q;
  logic [1:0]      err_code_q;
  logic [4:0]      body_len_q;

  logic len_ok;
  logic body_last;
  logic buf_wr;
  logic buf_swap;

  assign len_ok    = (iRxData >= 8'd2) && (iRxData <= LenMax);
  assign body_last = (idx_q + 5'd1) == cnt_q;
  assign buf_wr    = iRxValid && (state_q == StBody);
  assign buf_swap  = iRxValid && (state_q == StTail1) && (iRxData == ZIR_TAIL1) && !chk_err_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= StIdle;
      sum_q       <= 8'h00;
      cnt_q       <= 5'd0;
      idx_q       <= 5'd0;
      tmo_q       <= '0;
      chk_err_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ZIR_ERR_LEN;
      body_len_q  <= 5'd0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      // A byte always wins over a timeout landing in the same cycle.
      if (iRxValid) begin
        tmo_q <= '0;
        unique case (state_q)
          StIdle: begin
            if (iRxData == ZIR_HDR) begin
              sum_q   <= ZIR_HDR;
              state_q <= StLen;
            end
          end
          StLen: begin
            if (len_ok) begin
              cnt_q     <= iRxData[4:0] - 5'd1;
              sum_q     <= sum_q + iRxData;
              idx_q     <= 5'd0;
              chk_err_q <= 1'b0;
              state_q   <= StBody;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ZIR_ERR_LEN;
              state_q     <= StIdle;
            end
          end
          StBody: begin
            sum_q <= sum_q + iRxData;
            idx_q <= idx_q + 5'd1;
            if (body_last) begin
              state_q <= StChk;
            end
          end
          StChk: begin
            chk_err_q <= (iRxData != sum_q);
            state_q   <= StTail0;
          end
          StTail0: begin
            if (iRxData == ZIR_TAIL0) begin
              state_q <= StTail1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ZIR_ERR_TAIL;
              state_q     <= StIdle;
            end
          end
          StTail1: begin
            state_q <= StIdle;
            // A broken trailer is reported in preference to a checksum error.
            if (iRxData != ZIR_TAIL1) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ZIR_ERR_TAIL;
            end else if (chk_err_q) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ZIR_ERR_CHK;
            end else begin
              frame_ok_q <= 1'b1;
              body_len_q <= cnt_q;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle) begin
        if (tmo_q == TmoLimit) begin
          tmo_q       <= '0;
          frame_err_q <= 1'b1;
          err_code_q  <= ZIR_ERR_TMO;
          state_q     <= StIdle;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  zir_body_buf #(
    .MAX_BODY (MAX_BODY),
    .IdxW     (IdxW)
  ) u_body_buf (
    .clk_i     (iClk),
    .rst_i     (iRst),
    .wr_en_i   (buf_wr),
    .wr_idx_i  (idx_q[IdxW-1:0]),
    .wr_data_i (iRxData),
    .swap_i    (buf_swap),
    .rd_idx_i  (iRdIndex),
    .rd_len_i  (body_len_q),
    .rd_data_o (oRdData)
  );

  assign oBodyLen  = body_len_q;
  assign oFrameOk  = frame_ok_q;
  assign oFrameErr = frame_err_q;
  assign oErrCode  = err_code_q;
  assign oBusy     = (state_q != StIdle);

endmodule

// File: tb/tb_zir_resp_parser.sv
// Bench for zir_resp_parser: directed frames followed by random frame
// traffic, each cycle compared against a frame-level reference model that
// collects the bytes of the current frame in a queue and judges it by byte
// position.
module tb_zir_resp_parser;

  localparam int unsigned MAX_BODY = 16;
  localparam int unsigned TMO      = 64;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iRxValid = 1'b0;
  logic [7:0] iRxData = 8'h00;
  logic [3:0] iRdIndex = 4'd0;
  logic [7:0] oRdData;
  logic [4:0] oBodyLen;
  logic       oFrameOk;
  logic       oFrameErr;
  logic [1:0] oErrCode;
  logic       oBusy;

  zir_resp_parser #(
    .MAX_BODY    (MAX_BODY),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iRxValid  (iRxValid),
    .iRxData   (iRxData),
    .iRdIndex  (iRdIndex),
    .oRdData   (oRdData),
    .oBodyLen  (oBodyLen),
    .oFrameOk  (oFrameOk),
    .oFrameErr (oFrameErr),
    .oErrCode  (oErrCode),
    .oBusy     (oBusy)
  );

  always #5 iClk = ~iClk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  frame[$];      // bytes of the frame in progress, starting with AA
  int unsigned gap;           // idle cycles since the last byte of the frame
  logic [7:0]  mdl_body[16];
  int unsigned mdl_len;
  int unsigned mdl_code;
  bit          exp_ok;
  bit          exp_err;

  function automatic void mdl_reject(input int unsigned code);
    exp_err  = 1'b1;
    mdl_code = code;
    frame.delete();
  endfunction

  function automatic void mdl_reset();
    frame.delete();
    gap      = 0;
    mdl_len  = 0;
    mdl_code = 0;
    exp_ok   = 1'b0;
    exp_err  = 1'b0;
  endfunction

  function automatic void mdl_byte(input logic [7:0] b);
    int unsigned p;
    int unsigned len;
    logic [7:0]  sum;
    gap = 0;
    if (frame.size() == 0) begin
      if (b == 8'hAA) frame.push_back(b);
      return;
    end
    frame.push_back(b);
    p = frame.size() - 1;
    if (p == 1) begin
      if (b < 8'd2 || int'(b) > MAX_BODY + 1) mdl_reject(0);
      return;
    end
    len = int'(frame[1]);
    if (p <= len + 1) return;  // body bytes and checksum byte
    if (p == len + 2) begin
      if (b != 8'hEB) mdl_reject(2);
      return;
    end
    sum = 8'h00;
    for (int i = 0; i <= int'(len); i++) sum = sum + frame[i];
    if (b != 8'hAA) mdl_reject(2);
    else if (sum != frame[len + 1]) mdl_reject(1);
    else begin
      exp_ok  = 1'b1;
      mdl_len = len - 1;
      for (int i = 0; i < int'(len) - 1; i++) mdl_body[i] = frame[2 + i];
      frame.delete();
    end
  endfunction

  function automatic void mdl_idle();
    if (frame.size() != 0) begin
      gap++;
      if (gap == TMO) mdl_reject(3);
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic check_outputs(input logic [3:0] idx);
    logic [7:0] exp_rd;
    exp_rd = (int'(idx) < int'(mdl_len)) ? mdl_body[idx] : 8'h00;
    check_eq("frame_ok", oFrameOk, exp_ok);
    check_eq("frame_err", oFrameErr, exp_err);
    check_eq("err_code", oErrCode, mdl_code);
    check_eq("body_len", oBodyLen, mdl_len);
    check_eq("busy", oBusy, frame.size() != 0);
    check_eq("rd_data", oRdData, exp_rd);
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input logic [3:0] idx);
    @(negedge iClk);
    iRst     = 1'b0;
    iRxValid = v;
    iRxData  = d;
    iRdIndex = idx;
    exp_ok   = 1'b0;
    exp_err  = 1'b0;
    if (v) mdl_byte(d);
    else mdl_idle();
    @(posedge iClk);
    #1;
    check_outputs(idx);
  endtask

  task automatic reset_cycle();
    logic [3:0] idx;
    idx = 4'($urandom_range(0, 15));
    @(negedge iClk);
    iRst     = 1'b1;
    iRxValid = 1'($urandom_range(0, 1));
    iRxData  = 8'($urandom);
    iRdIndex = idx;
    mdl_reset();
    @(posedge iClk);
    #1;
    check_outputs(idx);
  endtask

  task automatic send_vec(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, v[8*(n-1-i) +: 8], 4'($urandom_range(0, 15)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 4'($urandom_range(0, 15)));
  endtask

  task automatic rand_gap();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 70) return;
    else if (r < 95) idle($urandom_range(1, 3));
    else if (r < 97) idle(TMO - 1);
    else idle(TMO + $urandom_range(0, 2));
  endtask

  task automatic rand_frame();
    logic [7:0]  fq[$];
    logic [7:0]  chk;
    int unsigned kind;
    int unsigned n;
    kind = $urandom_range(0, 9);
    n    = $urandom_range(1, MAX_BODY);
    if (kind == 9) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) fq.push_back(8'($urandom));
    end else if (kind == 6) begin
      fq.push_back(8'hAA);
      if ($urandom_range(0, 1) == 0) fq.push_back(8'($urandom_range(0, 1)));
      else fq.push_back(8'($urandom_range(MAX_BODY + 2, 255)));
    end else begin
      fq.push_back(8'hAA);
      fq.push_back(8'(n + 1));
      for (int i = 0; i < int'(n); i++) fq.push_back(8'($urandom));
      chk = 8'h00;
      foreach (fq[i]) chk = chk + fq[i];
      if (kind == 5) chk = chk ^ 8'($urandom_range(1, 255));
      fq.push_back(chk);
      fq.push_back(kind == 7 ? 8'($urandom_range(0, 8'hEA)) : 8'hEB);
      fq.push_back(kind == 8 ? 8'($urandom_range(0, 8'hA9)) : 8'hAA);
    end
    foreach (fq[i]) begin
      cycle(1'b1, fq[i], 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 199) == 0) begin
        reset_cycle();
        return;
      end
      rand_gap();
    end
  endtask

  initial begin
    mdl_reset();
    reset_cycle();
    reset_cycle();
    check_eq("rst_len", oBodyLen, 5'd0);
    check_eq("rst_code", oErrCode, 2'd0);

    // Good frame, then sweep the read port.
    send_vec(128'hAA_06_01_5D_02_05_40_55_EB_AA, 10);
    check_eq("t1_ok", oFrameOk, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 4'(i));
    check_eq("t1_len", oBodyLen, 5'd5);

    // Bad checksum leaves the committed body alone.
    send_vec(128'hAA_04_01_7F_02_31_EB_AA, 8);
    check_eq("t2_err", oFrameErr, 1'b1);
    check_eq("t2_code", oErrCode, 2'd1);
    check_eq("t2_len", oBodyLen, 5'd5);
    cycle(1'b0, 8'h00, 4'd1);
    check_eq("t2_rd1", oRdData, 8'h5D);

    // Garbage before the header, bytes every cycle.
    send_vec(128'h00_FF_AA_04_01_7F_02_30_EB_AA, 10);
    check_eq("t3_len", oBodyLen, 5'd3);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 4'(i));

    // LEN and trailer errors.
    send_vec(128'hAA_20, 2);
    check_eq("t4_code_len", oErrCode, 2'd0);
    send_vec(128'hAA_04_01_7F_02_30_EB_00, 8);
    check_eq("t4_code_tail", oErrCode, 2'd2);
    send_vec(128'hAA_01, 2);
    check_eq("t4_code_len1", oErrCode, 2'd0);

    // Timeout, then a byte landing exactly on the limit cycle.
    send_vec(128'hAA_06_01, 3);
    idle(TMO);
    check_eq("t5_code_tmo", oErrCode, 2'd3);
    check_eq("t5_busy", oBusy, 1'b0);
    send_vec(128'hAA_06_01, 3);
    idle(TMO - 1);
    send_vec(128'h5D_02_05_40_55_EB_AA, 7);
    check_eq("t5_ok_edge", oFrameOk, 1'b1);

    // Reset mid-frame.
    send_vec(128'hAA_06_01_5D, 4);
    reset_cycle();
    check_eq("t6_busy", oBusy, 1'b0);
    check_eq("t6_len", oBodyLen, 5'd0);
    send_vec(128'hAA_06_01_5D_02_05_40_55_EB_AA, 10);
    check_eq("t6_len_after", oBodyLen, 5'd5);

    // Random traffic.
    for (int f = 0; f < 300; f++) rand_frame();
    idle(TMO + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zir_resp_parser.md
Name: zir_resp_parser

Overview:
- Receive-side counterpart of the IR core config command path: parses response frames returned by the IR module over the UART byte stream.
- Frame format: AA, LEN, BODY[LEN-1], CHK, EB, AA. CHK is the mod-256 sum of AA, LEN and all BODY bytes.
- Validates each frame, buffers the body and raises a one-cycle done or error strobe.
- The sequencer that issues commands (CDS-3, Save) uses the result to decide between ACK and retry.

Parameters:
MAX_BODY, 16, maximum body bytes stored (LEN-1 <= MAX_BODY).
TIMEOUT_CYC, 100000, inter-byte timeout in iClk cycles while a frame is in progress.

Ports:
iClk  in  1  system clock
iRst  in  1  reset; synchronous, active-high
iRxValid  in  1  one-cycle strobe; iRxData is valid this cycle
iRxData  in  8  received byte
iRdIndex  in  4  body read address
oRdData  out  8  body byte at iRdIndex (combinational read of buffer)
oBodyLen  out  5  body length of the last good frame (LEN-1)
oFrameOk  out  1  one-cycle pulse: good frame accepted
oFrameErr  out  1  one-cycle pulse: frame rejected
oErrCode  out  2  0 bad LEN, 1 checksum, 2 trailer, 3 timeout; held until the next error
oBusy  out  1  high while the state is not IDLE

Behaviour:
- Reset: state IDLE; oFrameOk=0, oFrameErr=0, oErrCode=0, oBodyLen=0, oBusy=0, checksum accumulator=0, timeout counter=0. Buffer contents are don't-care, but oBodyLen=0 marks them invalid.
- States: IDLE, LEN, BODY, CHK, TAIL0, TAIL1. Transitions happen only on iRxValid, except timeout.
- IDLE: on byte AA, set sum=AA and go to LEN. Any other byte is ignored silently (resync).
- LEN:
  - If 2 <= byte <= MAX_BODY+1: latch cnt=byte-1, sum+=byte, go to BODY.
  - Otherwise: error code 0, go to IDLE.
- BODY: write byte to buf[idx], idx++, sum+=byte. Go to CHK once idx reaches cnt.
- CHK: compare byte with sum[7:0]. On mismatch, latch pending error code 1 but continue to TAIL0, so the whole frame is consumed before resync.
- TAIL0: expect EB; otherwise error code 2 and go to IDLE.
- TAIL1: expect AA.
  - If correct and no pending error: oFrameOk pulse, commit oBodyLen=cnt.
  - If a pending checksum error exists: oFrameErr pulse with code 1.
  - If the byte is not AA: code 2.
  - Always return to IDLE.
- Strobe latency: oFrameOk and oFrameErr assert on the cycle after the iRxValid that completes or breaks the frame, for exactly one cycle. They are never asserted together.
- Double buffering: the body is written into a shadow buffer and copied into the read buffer on the oFrameOk cycle, so oRdData stays stable for the last good frame while a new frame is received. The copy may be done as a bank swap.
- iRdIndex >= oBodyLen returns 0.
- Timeout:
  - The counter clears on every iRxValid and increments each cycle in any non-IDLE state.
  - Reaching TIMEOUT_CYC-1 gives oFrameErr with code 3 and a return to IDLE.
  - If iRxValid arrives in the same cycle the counter reaches the limit, the byte wins: it is processed and the counter clears.
- Back-to-back frames: the byte after TAIL1 is handled from IDLE with no gap cycles required. iRxValid may be asserted every cycle.
- Reset mid-frame: discard all progress. No strobes are generated.
- Arithmetic: sum is 8-bit and wraps; idx and cnt are 5-bit.
- A rejected frame never changes oBodyLen or the read buffer.

Decomposition:
- Shared package/include zir_pkg: constants ZIR_HDR=8'hAA, ZIR_TAIL0=8'hEB, ZIR_TAIL1=8'hAA, the error-code localparams, and the state encoding.
- The command ROM and this parser both use ZIR_HDR and ZIR_TAIL0/1 from it.
- One sub-module: zir_body_buf, the double-buffered MAX_BODY x 8 storage with swap and read port.
- FSM, checksum and timeout stay in the top.

Test Plan:
1. Send AA 06 01 5D 02 05 40 55 EB AA -> oFrameOk pulse one cycle after the last byte; oBodyLen=5; reading idx 0..4 gives 01 5D 02 05 40; idx 5 gives 00.
2. Send AA 04 01 7F 02 31 EB AA (bad CHK) -> oFrameErr, oErrCode=1; oBodyLen and the buffer are unchanged from test 1.
3. Send garbage 00 FF then AA 04 01 7F 02 30 EB AA with iRxValid every cycle -> garbage ignored; oFrameOk; oBodyLen=3; data 01 7F 02.
4. Send AA 20 (LEN > MAX_BODY+1) -> oFrameErr code 0. Send AA 04 01 7F 02 30 EB 00 -> code 2. Send AA 01 -> code 0.
5. Send AA 06 01 then idle TIMEOUT_CYC cycles -> oFrameErr code 3 and oBusy drops. Repeat with a byte landing exactly on the limit cycle -> no timeout.
6. Assert iRst after AA 06 01 5D -> no strobes, oBusy=0, oBodyLen=0. A subsequent valid frame is accepted normally.
